spmm_row_scheduler: RTL and testbench

Parametrised CSR-sparse × dense-weight scheduler with built-in multiply-accumulate lanes. It loads a group of NUM_LANES weight columns, each K rows deep, into local buffers. It then streams nonzero input elements (value, row, column), accumulates one dot product per lane, and emits one result vector per non-empty input row. It is the next-generation replacement for the fixed two-PE scheduler, with an arbitrary lane count, valid/ready handshakes on every stream, and fixed-point output scaling.

---
 rtl/spmm_row_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_spmm_row_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmm_row_scheduler.sv
// CSR-sparse x dense-weight row scheduler with NUM_LANES multiply-accumulate lanes.
// Build option: define SPMM_SAT_EN for saturating result narrowing (default wraps).
module spmm_row_scheduler #(
  parameter  int DATA_W    = 16,
  parameter  int K         = 32,
  parameter  int NUM_LANES = 2,
  parameter  int ROW_W     = 7,
  parameter  int OCOL_W    = 3,
  parameter  int ACC_W     = 40,
  parameter  int FRAC      = 0,
  localparam int COL_W     = $clog2(K)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [OCOL_W-1:0]             col_base,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic signed [DATA_W-1:0]      w_data,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic signed [DATA_W-1:0]      i_data,
  input  logic [ROW_W-1:0]              i_row,
  input  logic [COL_W-1:0]              i_col,
  input  logic                          i_last,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [ROW_W-1:0]              o_row,
  output logic [OCOL_W-1:0]             o_col,
  output logic [NUM_LANES*DATA_W-1:0]   o_result,
  output logic                          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int BROW_W = (K > 1) ? $clog2(K) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic [1:0]                        state_q, state_d;
  logic [LANE_W-1:0]                 lane_q, lane_d;
  logic [BROW_W-1:0]                 brow_q, brow_d;
  logic [OCOL_W-1:0]                 col_base_q, col_base_d;
  logic                              first_q, first_d;
  logic [ROW_W-1:0]                  cur_row_q, cur_row_d;
  logic signed [ACC_W-1:0]           acc_q [NUM_LANES];
  logic signed [ACC_W-1:0]           acc_d [NUM_LANES];
  logic signed [DATA_W-1:0]          buf_q [NUM_LANES][K];
  logic signed [DATA_W-1:0]          buf_d [NUM_LANES][K];
  logic                              o_valid_q, o_valid_d;
  logic [ROW_W-1:0]                  o_row_q, o_row_d;
  logic [OCOL_W-1:0]                 o_col_q, o_col_d;
  logic [NUM_LANES*DATA_W-1:0]       o_result_q, o_result_d;
  logic                              done_q, done_d;

  logic                              out_free;
  logic                              i_fire;
  logic                              col_in_range;
  logic signed [2*DATA_W-1:0]        mul;
  logic signed [ACC_W-1:0]           prod [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0]       acc_narrow;

  function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] y;
    y = x >>> FRAC;
`ifdef SPMM_SAT_EN
    if (y > SAT_MAX)
      narrow = SAT_MAX[DATA_W-1:0];
    else if (y < SAT_MIN)
      narrow = SAT_MIN[DATA_W-1:0];
    else
      narrow = y[DATA_W-1:0];
`else
    narrow = y[DATA_W-1:0];
`endif
  endfunction

  assign out_free = !o_valid_q || o_ready;
  assign w_ready  = (state_q == S_LOAD);
  assign i_ready  = (state_q == S_RUN) && out_free;
  assign i_fire   = i_valid && i_ready;

  assign o_valid  = o_valid_q;
  assign o_row    = o_row_q;
  assign o_col    = o_col_q;
  assign o_result = o_result_q;
  assign done     = done_q;

  // Column indices beyond the buffer depth contribute nothing and never read the buffer.
  assign col_in_range = ({1'b0, i_col} < (COL_W + 1)'(K));

  always_comb begin
    mul = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      prod[l] = '0;
      if (col_in_range) begin
        mul     = i_data * buf_q[l][i_col];
        prod[l] = ACC_W'(mul);
      end
    end
  end

  always_comb begin
    acc_narrow = '0;
    for (int l = 0; l < NUM_LANES; l++)
      acc_narrow[l*DATA_W +: DATA_W] = narrow(acc_q[l]);
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    brow_d     = brow_q;
    col_base_d = col_base_q;
    first_d    = first_q;
    cur_row_d  = cur_row_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    o_valid_d  = o_valid_q;
    o_row_d    = o_row_q;
    o_col_d    = o_col_q;
    o_result_d = o_result_q;
    done_d     = 1'b0;

    if (o_valid_q && o_ready)
      o_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          col_base_d = col_base;
          lane_d     = '0;
          brow_d     = '0;
          first_d    = 1'b1;
          for (int l = 0; l < NUM_LANES; l++)
            acc_d[l] = '0;
        end
      end

      // Beats are interleaved across lanes: consecutive beats fill the same buffer row.
      S_LOAD: begin
        if (w_valid) begin
          buf_d[lane_q][brow_q] = w_data;
          if (lane_q == LANE_W'(NUM_LANES - 1)) begin
            lane_d = '0;
            if (brow_q == BROW_W'(K - 1)) begin
              brow_d  = '0;
              state_d = S_RUN;
            end else begin
              brow_d = brow_q + BROW_W'(1);
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end

      S_RUN: begin
        if (i_fire) begin
          if (first_q || (i_row == cur_row_q)) begin
            for (int l = 0; l < NUM_LANES; l++)
              acc_d[l] = first_q ? prod[l] : acc_q[l] + prod[l];
          end else begin
            o_valid_d  = 1'b1;
            o_row_d    = cur_row_q;
            o_col_d    = col_base_q;
            o_result_d = acc_narrow;
            for (int l = 0; l < NUM_LANES; l++)
              acc_d[l] = prod[l];
          end
          first_d   = 1'b0;
          cur_row_d = i_row;
          if (i_last)
            state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (out_free) begin
          o_valid_d  = 1'b1;
          o_row_d    = cur_row_q;
          o_col_d    = col_base_q;
          o_result_d = acc_narrow;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      brow_q     <= '0;
      col_base_q <= '0;
      first_q    <= 1'b0;
      cur_row_q  <= '0;
      o_valid_q  <= 1'b0;
      o_row_q    <= '0;
      o_col_q    <= '0;
      o_result_q <= '0;
      done_q     <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        acc_q[l] <= '0;
        for (int r = 0; r < K; r++)
          buf_q[l][r] <= '0;
      end
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      brow_q     <= brow_d;
      col_base_q <= col_base_d;
      first_q    <= first_d;
      cur_row_q  <= cur_row_d;
      o_valid_q  <= o_valid_d;
      o_row_q    <= o_row_d;
      o_col_q    <= o_col_d;
      o_result_q <= o_result_d;
      done_q     <= done_d;
      for (int l = 0; l < NUM_LANES; l++) begin
        acc_q[l] <= acc_d[l];
        for (int r = 0; r < K; r++)
          buf_q[l][r] <= buf_d[l][r];
      end
    end
  end

endmodule

// File: tb/tb_spmm_row_scheduler.sv
// Scoreboard bench for spmm_row_scheduler (K=4 main instance, K=5 instance for out-of-range columns).
module tb_spmm_row_scheduler;

  localparam int DATA_W = 16;
  localparam int K      = 4;
  localparam int NL     = 2;
  localparam int ROW_W  = 7;
  localparam int OCOL_W = 3;
  localparam int ACC_W  = 40;
  localparam int FRAC   = 0;
  localparam int COL_W  = 2;
  localparam int K2     = 5;
  localparam int COL2_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     start = 1'b0;
  logic [OCOL_W-1:0]        col_base = '0;
  logic                     w_valid = 1'b0;
  logic                     w_ready;
  logic signed [DATA_W-1:0] w_data = '0;
  logic                     i_valid = 1'b0;
  logic                     i_ready;
  logic signed [DATA_W-1:0] i_data = '0;
  logic [ROW_W-1:0]         i_row = '0;
  logic [COL_W-1:0]         i_col = '0;
  logic                     i_last = 1'b0;
  logic                     o_valid;
  logic                     o_ready = 1'b1;
  logic [ROW_W-1:0]         o_row;
  logic [OCOL_W-1:0]        o_col;
  logic [NL*DATA_W-1:0]     o_result;
  logic                     done;

  logic                     b_start = 1'b0;
  logic                     b_w_valid = 1'b0;
  logic                     b_w_ready;
  logic signed [DATA_W-1:0] b_w_data = '0;
  logic                     b_i_valid = 1'b0;
  logic                     b_i_ready;
  logic signed [DATA_W-1:0] b_i_data = '0;
  logic [ROW_W-1:0]         b_i_row = '0;
  logic [COL2_W-1:0]        b_i_col = '0;
  logic                     b_i_last = 1'b0;
  logic                     b_o_valid;
  logic [ROW_W-1:0]         b_o_row;
  logic [OCOL_W-1:0]        b_o_col;
  logic [NL*DATA_W-1:0]     b_o_result;
  logic                     b_done;

  spmm_row_scheduler #(
    .DATA_W(DATA_W), .K(K), .NUM_LANES(NL), .ROW_W(ROW_W),
    .OCOL_W(OCOL_W), .ACC_W(ACC_W), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .col_base(col_base),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_row(i_row), .i_col(i_col), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_row(o_row),
    .o_col(o_col), .o_result(o_result), .done(done)
  );

  spmm_row_scheduler #(
    .DATA_W(DATA_W), .K(K2), .NUM_LANES(NL), .ROW_W(ROW_W),
    .OCOL_W(OCOL_W), .ACC_W(ACC_W), .FRAC(FRAC)
  ) dut_k5 (
    .clk(clk), .rst(rst), .start(b_start), .col_base(3'd3),
    .w_valid(b_w_valid), .w_ready(b_w_ready), .w_data(b_w_data),
    .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data),
    .i_row(b_i_row), .i_col(b_i_col), .i_last(b_i_last),
    .o_valid(b_o_valid), .o_ready(1'b1), .o_row(b_o_row),
    .o_col(b_o_col), .o_result(b_o_result), .done(b_done)
  );

  typedef struct {
    logic [ROW_W-1:0]     row;
    logic [OCOL_W-1:0]    col;
    logic [NL*DATA_W-1:0] res;
    logic                 last;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: weight buffers, per-lane accumulators and row tracking.
  logic signed [DATA_W-1:0] wm [NL][K];
  logic signed [ACC_W-1:0]  macc [NL];
  logic [ROW_W-1:0]         mrow;
  bit                       mfirst;
  logic [OCOL_W-1:0]        mcol;

  localparam logic signed [ACC_W-1:0] SMAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SMIN = -40'sd32768;

  function automatic logic [DATA_W-1:0] m_narrow(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] y;
    y = x >>> FRAC;
`ifdef SPMM_SAT_EN
    if (y > SMAX) y = SMAX;
    if (y < SMIN) y = SMIN;
`endif
    return y[DATA_W-1:0];
  endfunction

  task automatic m_push(input logic last);
    exp_t e;
    e.row  = mrow;
    e.col  = mcol;
    e.last = last;
    e.res  = '0;
    for (int l = 0; l < NL; l++)
      e.res[l*DATA_W +: DATA_W] = m_narrow(macc[l]);
    sb_q.push_back(e);
  endtask

  task automatic m_elem(input logic [ROW_W-1:0] row, input int col,
                        input logic signed [DATA_W-1:0] val, input logic last);
    logic signed [ACC_W-1:0]    p [NL];
    logic signed [2*DATA_W-1:0] m;
    for (int l = 0; l < NL; l++) begin
      m    = (col < K) ? val * wm[l][col] : '0;
      p[l] = ACC_W'(m);
    end
    if (!mfirst && row != mrow) begin
      m_push(1'b0);
      for (int l = 0; l < NL; l++) macc[l] = p[l];
    end else if (mfirst) begin
      for (int l = 0; l < NL; l++) macc[l] = p[l];
    end else begin
      for (int l = 0; l < NL; l++) macc[l] = macc[l] + p[l];
    end
    mrow   = row;
    mfirst = 0;
    if (last) m_push(1'b1);
  endtask

  task automatic do_start(input logic [OCOL_W-1:0] cb);
    @(posedge clk); #1;
    start    = 1'b1;
    col_base = cb;
    @(posedge clk); #1;
    start  = 1'b0;
    mcol   = cb;
    mfirst = 1;
    for (int l = 0; l < NL; l++) macc[l] = '0;
  endtask

  task automatic load_beats(input int first, input int n);
    int t;
    for (int b = first; b < first + n; b++) begin
      w_valid = 1'b1;
      w_data  = wm[b % NL][b / NL];
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 50) begin t++; @(negedge clk); end
      if (!w_ready) checkOutput("w_ready_timeout", w_ready, 1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [ROW_W-1:0] row, input int col,
                               input logic signed [DATA_W-1:0] val, input logic last);
    int t;
    i_valid = 1'b1;
    i_row   = row;
    i_col   = col[COL_W-1:0];
    i_data  = val;
    i_last  = last;
    t = 0;
    @(negedge clk);
    while (!i_ready && t < 100) begin t++; @(negedge clk); end
    if (!i_ready) checkOutput("i_ready_timeout", i_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    m_elem(row, col, val, last);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin t++; @(posedge clk); end
    checkOutput("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic set_weights_basic();
    for (int r = 0; r < K; r++) begin
      wm[0][r] = DATA_W'(r + 1);
      wm[1][r] = DATA_W'(r + 5);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_w_ready"}, w_ready, 0);
    checkOutput({tag, "_i_ready"}, i_ready, 0);
    checkOutput({tag, "_o_valid"}, o_valid, 0);
    checkOutput({tag, "_o_row"}, o_row, 0);
    checkOutput({tag, "_o_col"}, o_col, 0);
    checkOutput({tag, "_o_result"}, o_result, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks done/hold behaviour.
  logic                 prev_valid = 1'b0;
  logic                 prev_fire  = 1'b0;
  logic [NL*DATA_W-1:0] prev_res   = '0;
  logic                 new_out;
  exp_t                 mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      new_out = o_valid && (!prev_valid || prev_fire);
      if (new_out) begin
        if (sb_q.size() == 0) checkOutput("unexpected_out", o_valid, 0);
        else                  checkOutput("done_at_out", done, sb_q[0].last);
      end else if (done) begin
        checkOutput("stray_done", done, 0);
      end
      if (o_valid && prev_valid && !prev_fire) checkOutput("hold_stable", o_result, prev_res);
      if (o_valid && !o_ready) checkOutput("i_ready_full", i_ready, 0);
      if (o_valid && o_ready && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checkOutput("o_row", o_row, mon_e.row);
        checkOutput("o_col", o_col, mon_e.col);
        checkOutput("o_result", o_result, mon_e.res);
      end
      prev_valid = o_valid;
      prev_fire  = o_valid && o_ready;
      prev_res   = o_result;
    end
  end

  task automatic b_handshake(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!(b_w_ready || b_i_ready) && t < 50) begin t++; @(negedge clk); end
    if (!(b_w_ready || b_i_ready)) checkOutput(tag, 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    set_weights_basic();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_release");

    $display("[TB] reset mid-LOAD and mid-RUN");
    do_start(3'd1);
    load_beats(0, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_load");
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    do_start(3'd1);
    load_beats(0, 2 * K);
    applyStimulus(7'd0, 0, 16'sd5, 1'b0);
    applyStimulus(7'd1, 1, 16'sd3, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_reset_outputs("rst_run");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_o_valid", o_valid, 0);

    $display("[TB] load and accumulate");
    do_start(3'd2);
    load_beats(0, 2 * K);
    applyStimulus(7'd0, 0, 16'sd10, 1'b0);
    applyStimulus(7'd0, 3, 16'sd1, 1'b0);
    applyStimulus(7'd2, 1, -16'sd3, 1'b1);
    wait_drain();

    $display("[TB] backpressure");
    o_ready = 1'b0;
    do_start(3'd2);
    load_beats(0, 2 * K);
    fork
      begin
        applyStimulus(7'd0, 0, 16'sd10, 1'b0);
        applyStimulus(7'd0, 3, 16'sd1, 1'b0);
        applyStimulus(7'd2, 1, -16'sd3, 1'b0);
        applyStimulus(7'd2, 0, 16'sd1, 1'b1);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!o_valid && t < 100) begin t++; @(negedge clk); end
        if (!o_valid) checkOutput("bp_first_out_timeout", o_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    wait_drain();

    $display("[TB] empty rows");
    do_start(3'd5);
    load_beats(0, 2 * K);
    applyStimulus(7'd0, 1, 16'sd3, 1'b0);
    applyStimulus(7'd2, 2, -16'sd1, 1'b0);
    applyStimulus(7'd2, 3, 16'sd2, 1'b0);
    applyStimulus(7'd4, 0, 16'sd7, 1'b1);
    wait_drain();

    $display("[TB] ignored controls");
    do_start(3'd4);
    i_valid = 1'b1;
    i_row   = 7'd0;
    i_col   = 2'd0;
    i_data  = 16'sd99;
    load_beats(0, K);
    @(negedge clk);
    checkOutput("i_ready_in_load", i_ready, 0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    load_beats(K, K);
    applyStimulus(7'd1, 0, 16'sd2, 1'b0);
    start    = 1'b1;
    col_base = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("w_ready_in_run", w_ready, 0);
    @(posedge clk); #1;
    applyStimulus(7'd1, 1, 16'sd3, 1'b1);
    wait_drain();

    $display("[TB] saturation");
    for (int r = 0; r < K; r++) begin
      wm[0][r] = 16'sh7FFF;
      wm[1][r] = 16'sh7FFF;
    end
    do_start(3'd0);
    load_beats(0, 2 * K);
    for (int c = 0; c < K; c++)
      applyStimulus(7'd5, c, 16'sh7FFF, (c == K - 1));
    wait_drain();

    $display("[TB] out-of-range column on K=5 instance");
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int b = 0; b < 2 * K2; b++) begin
      b_w_valid = 1'b1;
      b_w_data  = (b % NL == 0) ? DATA_W'(b / NL + 1) : DATA_W'(10 * (b / NL + 1));
      b_handshake("k5_w_timeout");
    end
    b_w_valid = 1'b0;
    b_i_valid = 1'b1;
    b_i_row   = 7'd1;
    b_i_col = 3'd5; b_i_data = 16'sd7; b_handshake("k5_i_timeout");
    b_i_col = 3'd4; b_i_data = 16'sd1; b_handshake("k5_i_timeout");
    b_i_col = 3'd2; b_i_data = 16'sd2; b_i_last = 1'b1; b_handshake("k5_i_timeout");
    b_i_valid = 1'b0;
    b_i_last  = 1'b0;
    t = 0;
    @(negedge clk);
    while (!b_o_valid && t < 20) begin t++; @(negedge clk); end
    checkOutput("k5_o_valid", b_o_valid, 1);
    checkOutput("k5_o_row", b_o_row, 7'd1);
    checkOutput("k5_o_col", b_o_col, 3'd3);
    checkOutput("k5_o_result", b_o_result, 32'h006E_000B);
    checkOutput("k5_done", b_done, 1);

    repeat (3) @(posedge clk);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
